// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared widths and state type for the round-robin grant encoder
package rr_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-and-priority-encode starting at ptr
module rr_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  always_comb begin
    // Rotating right by ptr puts requester ptr at bit 0, so the lowest set bit wins.
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = W'(i);
      end
    end
    any = |req;
    idx = off + ptr;
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// rtl/rr_grant_encoder.sv - round-robin arbiter emitting a registered binary grant index
module rr_grant_encoder
  import rr_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic         busy
);

  rr_state_e    state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] grant_idx_q, grant_idx_d;
  logic         grant_valid_q, grant_valid_d;
  logic [W-1:0] scan_ptr;
  logic         pick_any;
  logic [W-1:0] pick_idx;

  // In GRANT the scan always starts just past the current winner, which is the
  // pointer value a handshake this cycle would commit.
  assign scan_ptr = (state_q == GRANT) ? grant_idx_q + 1'b1 : ptr_q;

  rr_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .req(req),
    .ptr(scan_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          ptr_d = grant_idx_q + 1'b1;
          if (pick_any) begin
            grant_idx_d = pick_idx;
          end else begin
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign busy        = grant_valid_q;

endmodule
